// File: rtl/hs32_xmem.sv
// hs32_xmem: bridges a 32-bit word request from the memory arbiter onto a
// 16-bit asynchronous external memory bus as two strobed halfword accesses
// (low half first, then high half), then pulses done for one cycle.
// Every bus-facing output is a register so the strobes are glitch-free.
module hs32_xmem #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic        rw,
  input  logic [31:0] dtw,
  output logic [31:0] dtr,
  input  logic        valid,
  output logic        done,
  output logic [31:0] ext_addr,
  input  logic [15:0] ext_din,
  output logic [15:0] ext_dout,
  output logic        ext_dout_en,
  output logic        ext_ce_n,
  output logic        ext_oe_n,
  output logic        ext_we_n,
  input  logic        ext_wait_n
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP_LO,
    STRB_LO,
    SETUP_HI,
    STRB_HI,
    DONE
  } state_t;

  localparam logic [3:0] WAIT_LAST = WAIT_CYCLES[3:0];

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] base;
  logic        wr;
  logic [31:0] wdata;

  logic strobe_end;
  assign strobe_end = (cnt == WAIT_LAST) && ext_wait_n;

  // Single FSM: each transition also loads the bus outputs for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      base        <= 32'd0;
      wr          <= 1'b0;
      wdata       <= 32'd0;
      dtr         <= 32'd0;
      done        <= 1'b0;
      ext_addr    <= 32'd0;
      ext_dout    <= 16'd0;
      ext_dout_en <= 1'b0;
      ext_ce_n    <= 1'b1;
      ext_oe_n    <= 1'b1;
      ext_we_n    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            base        <= {addr[31:2], 2'b00};
            wr          <= rw;
            wdata       <= dtw;
            state       <= SETUP_LO;
            ext_ce_n    <= 1'b0;
            ext_oe_n    <= 1'b1;
            ext_we_n    <= 1'b1;
            ext_addr    <= {addr[31:2], 2'b00};
            ext_dout_en <= rw;
            ext_dout    <= rw ? dtw[15:0] : 16'h0000;
          end
        end

        SETUP_LO: begin
          state <= STRB_LO;
          cnt   <= 4'd1;
          if (wr) begin
            ext_we_n <= 1'b0;
          end else begin
            ext_oe_n <= 1'b0;
          end
        end

        STRB_LO: begin
          if (strobe_end) begin
            if (!wr) begin
              dtr[15:0] <= ext_din;
            end
            state    <= SETUP_HI;
            cnt      <= 4'd0;
            ext_oe_n <= 1'b1;
            ext_we_n <= 1'b1;
            ext_addr <= base + 32'd2;
            ext_dout <= wr ? wdata[31:16] : 16'h0000;
          end else if (cnt != WAIT_LAST) begin
            cnt <= cnt + 4'd1;
          end
        end

        SETUP_HI: begin
          state <= STRB_HI;
          cnt   <= 4'd1;
          if (wr) begin
            ext_we_n <= 1'b0;
          end else begin
            ext_oe_n <= 1'b0;
          end
        end

        STRB_HI: begin
          if (strobe_end) begin
            if (!wr) begin
              dtr[31:16] <= ext_din;
            end
            state       <= DONE;
            cnt         <= 4'd0;
            done        <= 1'b1;
            ext_ce_n    <= 1'b1;
            ext_oe_n    <= 1'b1;
            ext_we_n    <= 1'b1;
            ext_dout_en <= 1'b0;
            ext_dout    <= 16'h0000;
          end else if (cnt != WAIT_LAST) begin
            cnt <= cnt + 4'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs32_xmem.sv
// tb_hs32_xmem: scoreboard bench for hs32_xmem. Stimulus pushes the expected
// strobe phases and done responses; a negedge monitor pops and compares them.
module tb_hs32_xmem;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        rw = 1'b0;
  logic [31:0] dtw = 32'd0;
  logic [31:0] dtr;
  logic        valid = 1'b0;
  logic        done;
  logic [31:0] ext_addr;
  logic [15:0] ext_din;
  logic [15:0] ext_dout;
  logic        ext_dout_en;
  logic        ext_ce_n;
  logic        ext_oe_n;
  logic        ext_we_n;
  logic        ext_wait_n = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] dtr;
    int          cyc;
  } done_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [15:0] data;
    int          len;
  } strb_exp_t;

  done_exp_t done_q[$];
  strb_exp_t strb_q[$];

  hs32_xmem #(.WAIT_CYCLES(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .addr        (addr),
    .rw          (rw),
    .dtw         (dtw),
    .dtr         (dtr),
    .valid       (valid),
    .done        (done),
    .ext_addr    (ext_addr),
    .ext_din     (ext_din),
    .ext_dout    (ext_dout),
    .ext_dout_en (ext_dout_en),
    .ext_ce_n    (ext_ce_n),
    .ext_oe_n    (ext_oe_n),
    .ext_we_n    (ext_we_n),
    .ext_wait_n  (ext_wait_n)
  );

  // Free-running clock and cycle counter used to time done pulses.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External memory contents seen by reads.
  function automatic logic [15:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_1000: mem_rd = 16'hBEEF;
      32'h0000_1002: mem_rd = 16'hDEAD;
      32'h0000_0040: mem_rd = 16'h1111;
      32'h0000_0042: mem_rd = 16'h2222;
      32'hFFFF_FFFC: mem_rd = 16'hCAFE;
      32'hFFFF_FFFE: mem_rd = 16'hF00D;
      default:       mem_rd = a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  assign ext_din = mem_rd(ext_addr);

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d",
               name, actual, expected, cyc);
    end
  endtask

  // Queue the two strobe phases and the done response of one transaction.
  task automatic push_txn(input logic [31:0] lo_addr, input logic [31:0] hi_addr,
                          input logic wr, input logic [31:0] d,
                          input logic [31:0] exp_dtr, input int acc_cyc,
                          input int extra);
    strb_q.push_back('{lo_addr, wr, wr ? d[15:0] : 16'h0000, W});
    strb_q.push_back('{hi_addr, wr, wr ? d[31:16] : 16'h0000, W + extra});
    // The cycle that starts at the accepting edge is the first of 2W+3+extra.
    done_q.push_back('{exp_dtr, acc_cyc + 2 * W + 2 + extra});
  endtask

  // One isolated transaction; ext_wait_n is held low in cycles ws..ws+wl-1.
  task automatic apply_stimulus(input logic [31:0] a, input logic r,
                                input logic [31:0] d, input logic [31:0] lo_addr,
                                input logic [31:0] hi_addr, input logic [31:0] exp_dtr,
                                input int ws, input int wl);
    int acc;
    @(posedge clk);
    #1;
    addr  = a;
    rw    = r;
    dtw   = d;
    valid = 1'b1;
    acc   = cyc + 1;
    push_txn(lo_addr, hi_addr, r, d, exp_dtr, acc, wl);
    for (int rel = 1; rel <= 2 * W + 4 + wl; rel++) begin
      @(posedge clk);
      #1;
      if (rel == 1) begin
        valid = 1'b0;
        addr  = ~a;
        rw    = ~r;
        dtw   = ~d;
      end
      ext_wait_n = !(wl > 0 && rel >= ws && rel < ws + wl);
    end
    ext_wait_n = 1'b1;
  endtask

  logic      prev_strobe = 1'b0;
  logic      have_cur = 1'b0;
  int        cur_len = 0;
  strb_exp_t cur;

  // Monitor: invariants every cycle, strobe phases and done responses popped from the queues.
  always @(negedge clk) begin
    logic strobe;
    done_exp_t de;
    check_output("no_x", {31'd0, $isunknown({dtr, done, ext_addr, ext_dout,
                 ext_dout_en, ext_ce_n, ext_oe_n, ext_we_n})}, 32'd0);
    check_output("oe_we_exclusive", {31'd0, (!ext_oe_n && !ext_we_n)}, 32'd0);
    if (ext_ce_n) check_output("dout_en_idle", {31'd0, ext_dout_en}, 32'd0);
    strobe = !ext_oe_n || !ext_we_n;
    if (!reset_n) begin
      prev_strobe = 1'b0;
      have_cur    = 1'b0;
    end else begin
      if (strobe && !prev_strobe) begin
        if (strb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL strobe_unexpected: got strobe at 0x%08h, expected none", ext_addr);
        end else begin
          cur      = strb_q.pop_front();
          have_cur = 1'b1;
          cur_len  = 0;
        end
      end
      if (strobe && have_cur) begin
        cur_len++;
        check_output("strobe_addr", ext_addr, cur.addr);
        check_output("strobe_kind_we_n", {31'd0, ext_we_n}, {31'd0, !cur.wr});
        check_output("strobe_dout_en", {31'd0, ext_dout_en}, {31'd0, cur.wr});
        check_output("strobe_ce_n", {31'd0, ext_ce_n}, 32'd0);
        if (cur.wr) check_output("strobe_dout", {16'd0, ext_dout}, {16'd0, cur.data});
      end
      if (!strobe && prev_strobe && have_cur) begin
        check_output("strobe_len", cur_len, cur.len);
        have_cur = 1'b0;
      end
      prev_strobe = strobe;
    end
    if (done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
      end else begin
        de = done_q.pop_front();
        check_output("done_dtr", dtr, de.dtr);
        check_output("done_cycle", cyc, de.cyc);
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    int acc1;
    int acc2;
    #12;
    check_output("rst_ce_n", {31'd0, ext_ce_n}, 32'd1);
    check_output("rst_oe_n", {31'd0, ext_oe_n}, 32'd1);
    check_output("rst_we_n", {31'd0, ext_we_n}, 32'd1);
    check_output("rst_dout_en", {31'd0, ext_dout_en}, 32'd0);
    check_output("rst_done", {31'd0, done}, 32'd0);
    check_output("rst_ext_addr", ext_addr, 32'd0);
    check_output("rst_ext_dout", {16'd0, ext_dout}, 32'd0);
    check_output("rst_dtr", dtr, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Read with unaligned address bits ignored.
    apply_stimulus(32'h0000_1003, 1'b0, 32'd0, 32'h0000_1000, 32'h0000_1002,
                   32'hDEAD_BEEF, 0, 0);
    // Write: dtr must keep the previous read word.
    apply_stimulus(32'h0000_0020, 1'b1, 32'h1234_5678, 32'h0000_0020, 32'h0000_0022,
                   32'hDEAD_BEEF, 0, 0);
    // Read with the device holding wait low for 3 cycles at the end of STRB_HI.
    apply_stimulus(32'h0000_0040, 1'b0, 32'd0, 32'h0000_0040, 32'h0000_0042,
                   32'h2222_1111, 6, 3);

    // Reset asserted during the low-half write strobe.
    @(posedge clk);
    #1;
    addr  = 32'h0000_0080;
    rw    = 1'b1;
    dtw   = 32'hAAAA_5555;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    check_output("abort_setup_addr", ext_addr, 32'h0000_0080);
    check_output("abort_setup_dout_en", {31'd0, ext_dout_en}, 32'd1);
    @(posedge clk);
    #1;
    check_output("abort_strobe_we_n", {31'd0, ext_we_n}, 32'd0);
    check_output("abort_strobe_dout", {16'd0, ext_dout}, 32'h0000_5555);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("abort_we_n", {31'd0, ext_we_n}, 32'd1);
    check_output("abort_ce_n", {31'd0, ext_ce_n}, 32'd1);
    check_output("abort_dout_en", {31'd0, ext_dout_en}, 32'd0);
    check_output("abort_dtr", dtr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply_stimulus(32'h0000_1000, 1'b0, 32'd0, 32'h0000_1000, 32'h0000_1002,
                   32'hDEAD_BEEF, 0, 0);

    // Back-to-back: wrap-around read then write with valid held high throughout.
    @(posedge clk);
    #1;
    addr  = 32'hFFFF_FFFC;
    rw    = 1'b0;
    dtw   = 32'd0;
    valid = 1'b1;
    acc1  = cyc + 1;
    acc2  = acc1 + 2 * W + 4;
    push_txn(32'hFFFF_FFFC, 32'hFFFF_FFFE, 1'b0, 32'd0, 32'hF00D_CAFE, acc1, 0);
    push_txn(32'h0000_0100, 32'h0000_0102, 1'b1, 32'h9ABC_DEF0, 32'hF00D_CAFE, acc2, 0);
    @(posedge clk);
    #1;
    addr = 32'h0000_0100;
    rw   = 1'b1;
    dtw  = 32'h9ABC_DEF0;
    repeat (2 * W + 4) @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (2 * W + 5) @(posedge clk);
    #1;

    check_output("done_queue_drained", done_q.size(), 32'd0);
    check_output("strobe_queue_drained", strb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
